// File: rtl/par_serial_scheduler.sv
// par_serial_scheduler
// Round-robin arbiter and frame sequencer in front of a 6-bit
// parallel-to-serial shifter. Four requesters compete for the shifter. A
// winning word is captured in IDLE, loaded with a one-cycle ld/ack strobe,
// then shifted out MSB first over six cycles. An optional idle gap follows
// before the next arbitration.
//
// Every output comes from a flop. The combinational process computes the
// value each output must show in the coming cycle. The sequential process
// registers that value, so outputs always match the state the FSM is in.

module par_serial_scheduler #(
    parameter int GAP_CYCLES = 1          // idle cycles after each frame, 0..3
) (
    input  logic        clk,
    input  logic        reset,            // synchronous, active high
    input  logic [3:0]  req,
    input  logic [23:0] req_data,
    output logic        ld,
    output logic [5:0]  par_data,
    output logic [1:0]  grant,
    output logic [3:0]  ack,
    output logic        busy,
    output logic [2:0]  shift_bit,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    // The gap counter holds the number of GAP cycles still to follow the
    // current one, so it is preloaded with GAP_CYCLES-1.
    localparam logic [1:0] GAP_INIT = (GAP_CYCLES > 0) ? 2'(GAP_CYCLES - 1) : 2'd0;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [1:0]  r_rr_ptr;
    logic [1:0]  r_gap_cnt;
    logic        r_ld;
    logic [5:0]  r_par_data;
    logic [1:0]  r_grant;
    logic [3:0]  r_ack;
    logic        r_busy;
    logic [2:0]  r_shift_bit;
    logic        r_done;

    // Next-cycle values
    state_t      w_state_nxt;
    logic [1:0]  w_rr_ptr_nxt;
    logic [1:0]  w_gap_cnt_nxt;
    logic        w_ld_nxt;
    logic [5:0]  w_par_data_nxt;
    logic [1:0]  w_grant_nxt;
    logic [3:0]  w_ack_nxt;
    logic        w_shift_nxt_valid;
    logic [2:0]  w_shift_bit_nxt;
    logic        w_done_nxt;

    // Arbitration results
    logic [1:0]  w_winner;
    logic [5:0]  w_winner_data;

    // Round-robin pick. The scan runs from the farthest offset down to
    // rr_ptr itself, so the last hit is the requester closest to the pointer.
    always_comb begin
        w_winner = r_rr_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (req[r_rr_ptr + 2'(i)]) begin
                w_winner = r_rr_ptr + 2'(i);
            end
        end
    end

    // Select the winner's word from the flattened request bus
    assign w_winner_data = req_data[6 * w_winner +: 6];

    // Next-state and next-output decode for the frame sequencer
    always_comb begin
        // NOTE: every signal gets a default before the case statement.
        // A path that leaves one unassigned would infer a latch.
        w_state_nxt       = r_state;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_gap_cnt_nxt     = r_gap_cnt;
        w_ld_nxt          = 1'b0;
        w_par_data_nxt    = r_par_data;
        w_grant_nxt       = r_grant;
        w_ack_nxt         = 4'b0000;
        w_shift_nxt_valid = 1'b0;
        w_shift_bit_nxt   = 3'd0;
        w_done_nxt        = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Capture the winner's word now. Later changes on
                // req/req_data cannot reach the frame in flight.
                if (|req) begin
                    w_state_nxt    = S_LOAD;
                    w_grant_nxt    = w_winner;
                    w_par_data_nxt = w_winner_data;
                    w_rr_ptr_nxt   = w_winner + 2'd1;
                    w_ld_nxt       = 1'b1;
                    w_ack_nxt      = 4'b0001 << w_winner;
                end
            end

            S_LOAD: begin
                w_state_nxt       = S_SHIFT;
                w_shift_nxt_valid = 1'b1;
                w_shift_bit_nxt   = 3'd5;
            end

            S_SHIFT: begin
                if (r_shift_bit == 3'd0) begin
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt   = S_GAP;
                        w_gap_cnt_nxt = GAP_INIT;
                    end else begin
                        w_state_nxt   = S_IDLE;
                    end
                end else begin
                    w_shift_nxt_valid = 1'b1;
                    w_shift_bit_nxt   = r_shift_bit - 3'd1;
                    // done accompanies the cycle that emits bit 0
                    w_done_nxt        = (r_shift_bit == 3'd1);
                end
            end

            S_GAP: begin
                if (r_gap_cnt == 2'd0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 2'd1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and output flops. Reset overrides everything,
    // so a frame that is cut short is dropped and never resumed.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // flop samples the values from before the edge.
        if (reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= 2'd0;
            r_gap_cnt   <= 2'd0;
            r_ld        <= 1'b0;
            r_par_data  <= 6'd0;
            r_grant     <= 2'd0;
            r_ack       <= 4'b0000;
            r_busy      <= 1'b0;
            r_shift_bit <= 3'd0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_ld        <= w_ld_nxt;
            r_par_data  <= w_par_data_nxt;
            r_grant     <= w_grant_nxt;
            r_ack       <= w_ack_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_shift_bit <= w_shift_nxt_valid ? w_shift_bit_nxt : 3'd0;
            r_done      <= w_done_nxt;
        end
    end

    assign ld        = r_ld;
    assign par_data  = r_par_data;
    assign grant     = r_grant;
    assign ack       = r_ack;
    assign busy      = r_busy;
    assign shift_bit = r_shift_bit;
    assign done      = r_done;

endmodule

// File: tb/tb_par_serial_scheduler.sv
// tb_par_serial_scheduler
// Two instances share the same stimulus: GAP_CYCLES=1 (the default) and
// GAP_CYCLES=0. A frame-level reference model predicts each instance's
// outputs. When an IDLE cycle sees a request, the model picks the
// round-robin winner and queues the complete per-cycle output trace of
// that frame. While its queue is empty, an instance is idle.

module tb_par_serial_scheduler;

    typedef struct packed {
        logic       ld;
        logic [3:0] ack;
        logic [1:0] grant;
        logic [5:0] par;
        logic       busy;
        logic [2:0] sb;
        logic       done;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [23:0] req_data;

    logic        d_ld        [2];
    logic [5:0]  d_par_data  [2];
    logic [1:0]  d_grant     [2];
    logic [3:0]  d_ack       [2];
    logic        d_busy      [2];
    logic [2:0]  d_shift_bit [2];
    logic        d_done      [2];

    par_serial_scheduler #(.GAP_CYCLES(1)) u_dut_gap1 (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .ld        (d_ld[0]),
        .par_data  (d_par_data[0]),
        .grant     (d_grant[0]),
        .ack       (d_ack[0]),
        .busy      (d_busy[0]),
        .shift_bit (d_shift_bit[0]),
        .done      (d_done[0])
    );

    par_serial_scheduler #(.GAP_CYCLES(0)) u_dut_gap0 (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .ld        (d_ld[1]),
        .par_data  (d_par_data[1]),
        .grant     (d_grant[1]),
        .ack       (d_ack[1]),
        .busy      (d_busy[1]),
        .shift_bit (d_shift_bit[1]),
        .done      (d_done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state, one slot per instance
    int   m_gap  [2] = '{1, 0};
    exp_t m_q    [2][$];
    exp_t m_cur  [2];
    int   m_rr   [2];
    int   m_grant[2];
    int   m_par  [2];
    bit   m_idle [2];

    // Observation logs
    bit   rec_on;
    int   ack_log[$];
    int   ld_t   [2][$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int rr_pick(input int rr, input logic [3:0] r);
        for (int i = 0; i < 4; i++) begin
            if (r[(rr + i) % 4]) return (rr + i) % 4;
        end
        return 0;
    endfunction

    function automatic exp_t mk(input logic l, input logic [3:0] a, input int g, input int p,
                                input logic b, input int s, input logic dn);
        exp_t e;
        e.ld    = l;
        e.ack   = a;
        e.grant = 2'(g);
        e.par   = 6'(p);
        e.busy  = b;
        e.sb    = 3'(s);
        e.done  = dn;
        return e;
    endfunction

    // Advance instance k's model across the coming edge, using the inputs
    // that the DUT is about to sample.
    task automatic model_step(input int k);
        int w;
        if (reset) begin
            m_q[k].delete();
            m_rr[k]    = 0;
            m_grant[k] = 0;
            m_par[k]   = 0;
            m_idle[k]  = 1;
            m_cur[k]   = mk(0, 4'b0, 0, 0, 0, 0, 0);
            return;
        end
        if (m_idle[k] && req != 4'b0) begin
            w          = rr_pick(m_rr[k], req);
            m_rr[k]    = (w + 1) % 4;
            m_grant[k] = w;
            m_par[k]   = int'((req_data >> (6 * w)) & 24'h3f);
            m_q[k].push_back(mk(1, 4'(1 << w), w, m_par[k], 1, 0, 0));
            for (int b = 5; b >= 0; b--)
                m_q[k].push_back(mk(0, 4'b0, w, m_par[k], 1, b, b == 0));
            for (int g = 0; g < m_gap[k]; g++)
                m_q[k].push_back(mk(0, 4'b0, w, m_par[k], 1, 0, 0));
        end
        if (m_q[k].size() == 0) begin
            m_cur[k]  = mk(0, 4'b0, m_grant[k], m_par[k], 0, 0, 0);
            m_idle[k] = 1;
        end else begin
            m_cur[k]  = m_q[k].pop_front();
            m_idle[k] = 0;
        end
    endtask

    // One clock cycle: run the models, take the edge, then compare both
    // instances.
    task automatic tick();
        string p;
        for (int k = 0; k < 2; k++) model_step(k);
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? "g1_" : "g0_";
            check({p, "ld"},        32'(d_ld[k]),        32'(m_cur[k].ld));
            check({p, "ack"},       32'(d_ack[k]),       32'(m_cur[k].ack));
            check({p, "grant"},     32'(d_grant[k]),     32'(m_cur[k].grant));
            check({p, "par_data"},  32'(d_par_data[k]),  32'(m_cur[k].par));
            check({p, "busy"},      32'(d_busy[k]),      32'(m_cur[k].busy));
            check({p, "shift_bit"}, 32'(d_shift_bit[k]), 32'(m_cur[k].sb));
            check({p, "done"},      32'(d_done[k]),      32'(m_cur[k].done));
            if (rec_on && d_ld[k]) ld_t[k].push_back(cyc);
        end
        if (rec_on && d_ack[0] != 4'b0) begin
            check("ack_onehot", 32'($countones(d_ack[0])), 32'd1);
            for (int i = 0; i < 4; i++)
                if (d_ack[0][i]) ack_log.push_back(i);
        end
    endtask

    task automatic idle_ticks(input int n);
        req = 4'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int exp_grants[5] = '{0, 1, 2, 3, 0};
        bit found;

        reset    = 1'b1;
        req      = 4'b0;
        req_data = 24'h0;
        rec_on   = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Single request, slice 0 = 101101
        req_data = {6'h15, 6'h2a, 6'h3f, 6'b101101};
        req      = 4'b0001;
        tick();
        req = 4'b0000;
        check("single_ld", 32'(d_ld[0]), 32'd1);
        check("single_par", 32'(d_par_data[0]), 32'b101101);
        idle_ticks(12);

        // Contention from reset: all four held
        do_reset();
        rec_on   = 1'b1;
        req_data = 24'($urandom);
        req      = 4'b1111;
        for (int i = 0; i < 48; i++) tick();
        rec_on = 1'b0;
        idle_ticks(10);
        check("rr_count", 32'(ack_log.size() >= 5), 32'd1);
        for (int i = 0; i < 5 && i < ack_log.size(); i++)
            check("rr_order", 32'(ack_log[i]), 32'(exp_grants[i]));
        check("period_n", 32'(ld_t[0].size() >= 5 && ld_t[1].size() >= 5), 32'd1);
        for (int i = 1; i < 5 && i < ld_t[0].size() && i < ld_t[1].size(); i++) begin
            check("period_gap1", 32'(ld_t[0][i] - ld_t[0][i-1]), 32'd9);
            check("period_gap0", 32'(ld_t[1][i] - ld_t[1][i-1]), 32'd8);
        end

        // Pointer wrap: grant 2, then 0101 gives grant 0 and then 2
        do_reset();
        req = 4'b0100;
        tick();
        idle_ticks(10);
        req = 4'b0101;
        tick();
        check("wrap_first", 32'(d_grant[0]), 32'd0);
        for (int i = 0; i < 9; i++) tick();
        check("wrap_second", 32'(d_grant[0]), 32'd2);
        idle_ticks(10);

        // Disturbance during SHIFT: drop req and change data every cycle
        req      = 4'b0010;
        req_data = 24'($urandom);
        tick();
        for (int i = 0; i < 10; i++) begin
            req      = 4'b0000;
            req_data = 24'($urandom);
            tick();
        end

        // Reset mid-frame at shift_bit 3, then req 0010 goes to requester 1
        do_reset();
        req = 4'b0001;
        tick();
        req   = 4'b0000;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (d_busy[0] && d_shift_bit[0] == 3'd3) found = 1'b1;
        end
        check("reach_shift3", 32'(found), 32'd1);
        do_reset();
        check("rst_busy", 32'(d_busy[0]), 32'd0);
        req = 4'b0010;
        tick();
        req = 4'b0000;
        check("rst_regrant", 32'(d_grant[0]), 32'd1);
        idle_ticks(10);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 79) == 0);
            req      = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            req_data = 24'($urandom);
            tick();
        end
        reset = 1'b0;
        idle_ticks(12);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/par_serial_scheduler.md
PAR_SERIAL_SCHEDULER -- requirements
Module: par_serial_scheduler

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 1, meaning idle cycles inserted after each frame's last shift cycle (legal 0..3).
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port req  input  4  per-requester transmit request, level-held until ack.
REQ-005 SHALL have port req_data  input  24  requester k word at bits [6k+5:6k].
REQ-006 SHALL have port ld  output  1  load strobe to the 6-bit parallel-to-serial shifter.
REQ-007 SHALL have port par_data  output  6  word presented to the shifter's parallel input.
REQ-008 SHALL have port grant  output  2  index of the requester currently owning the shifter.
REQ-009 SHALL have port ack  output  4  one-hot, one-cycle capture acknowledge.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port shift_bit  output  3  index of the bit the shifter emits at the end of the current cycle.
REQ-012 SHALL have port done  output  1  one-cycle pulse on a frame's last shift cycle.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, SHIFT, GAP; all outputs registered.
REQ-014 IDLE: if any req bit is high at a clock edge, SHALL move to LOAD, set grant to the round-robin winner, and capture that requester's req_data slice into par_data at the same edge.
REQ-015 Round-robin: search starts at rr_ptr and wraps 3->0; on each grant, rr_ptr SHALL become (grant+1) mod 4.
REQ-016 LOAD (exactly 1 cycle): ld=1, ack[grant]=1, all other ack bits 0; next state SHIFT with bit counter=5.
REQ-017 SHIFT (exactly 6 cycles): ld=0, shift_bit = counter (5,4,3,2,1,0), counter decrements each cycle.
REQ-018 On the SHIFT cycle with shift_bit=0, done=1; next state GAP if GAP_CYCLES>0, else IDLE.
REQ-019 GAP SHALL last exactly GAP_CYCLES cycles with ld=0, then return to IDLE.
REQ-020 ld SHALL never be high outside LOAD; no shifter reload may occur mid-frame.
REQ-021 Frame period SHALL be 1 IDLE + 1 LOAD + 6 SHIFT + GAP_CYCLES cycles; req is sampled only in IDLE.
REQ-022 Latency: req high at edge E in IDLE -> ld=1 and ack in the cycle immediately after E.
REQ-023 req deasserted or req_data changed after ack SHALL NOT affect the frame in progress; par_data holds until the next capture.
REQ-024 A requester that holds req after its ack SHALL be re-arbitrated on the next IDLE cycle like any other.
REQ-025 grant and par_data SHALL hold their values in IDLE until the next grant.

Reset
REQ-026 With reset high at an edge: state=IDLE, ld=0, ack=0, done=0, busy=0, grant=0, par_data=0, shift_bit=0, rr_ptr=0, counters=0.
REQ-027 Reset SHALL take priority over all FSM activity, including mid-SHIFT or in LOAD; the aborted frame is not resumed and no ack/done is issued for it afterward.
REQ-028 The first request cycle after reset release SHALL follow REQ-014 normally.

Verification
REQ-029 Single request: req=0001, slice0=6'b101101, GAP=1 -> ld and ack=0001 in one cycle, par_data=101101, shift_bit 5..0 over 6 cycles, done on the 6th, busy low 2 cycles later.
REQ-030 Contention: req=1111 held continuously after reset -> grants 0,1,2,3,0 in order, one frame each, each with exactly one ack pulse.
REQ-031 Pointer wrap: after a grant to 2, req=0101 -> grant 0 (search starts at 3, wraps to 0), then grant 2.
REQ-032 Mid-frame disturbance: during SHIFT, drop req and change req_data -> par_data, shift_bit sequence, and done are unchanged; ld stays 0.
REQ-033 Reset mid-frame: assert reset at shift_bit=3 -> next cycle busy=0, ld=0, grant=0; no done; with req=0010 after release, grant=1 (rr_ptr back at 0).
REQ-034 GAP_CYCLES=0: back-to-back requests -> exactly one IDLE cycle between done and the next ld; frame period 8 cycles.
